// File: rtl/prewish_mask_sender_if.sv
// Handshake bundle between the mask sender (master) and the receiving blinky (slave).
// Signal names keep the external pin names of the sender.
interface prewish_mask_sender_if;
    logic       EN_I;
    logic       CLR_I;
    logic       ACK_I;
    logic       STB_O;
    logic [7:0] DAT_O;
    logic       BUSY_O;
    logic       ERR_O;
    logic       OVR_O;

    modport master (
        input  EN_I,
        input  CLR_I,
        input  ACK_I,
        output STB_O,
        output DAT_O,
        output BUSY_O,
        output ERR_O,
        output OVR_O
    );

    modport slave (
        output EN_I,
        output CLR_I,
        output ACK_I,
        input  STB_O,
        input  DAT_O,
        input  BUSY_O,
        input  ERR_O,
        input  OVR_O
    );
endinterface

// File: rtl/prewish_mask_sender.sv
// Periodically offers a new 8-bit mask to a blinky and waits (bounded) for its ACK.
// Define PREWISH_MASK_LFSR_EN to source masks from an 8-bit LFSR instead of the fixed table.
module prewish_mask_sender #(
    parameter int NEWMASK_CLK_BITS = 26,
    parameter int ACK_TIMEOUT_BITS = 4
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    prewish_mask_sender_if.master bus
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                        state_reg;
    logic [NEWMASK_CLK_BITS-1:0]   tick_cnt_reg;
    logic [ACK_TIMEOUT_BITS-1:0]   to_cnt_reg;
    logic                          stb_reg;
    logic [7:0]                    dat_reg;
    logic                          busy_reg;
    logic                          err_reg;
    logic                          ovr_reg;

    logic                          tick;
    logic                          to_expired;
    logic                          mask_adv;
    logic [7:0]                    mask_cur;

    assign tick       = &tick_cnt_reg;
    assign to_expired = &to_cnt_reg;
    // Only an accepted mask moves the source on; a timeout retries the same value.
    assign mask_adv   = (state_reg == SEND) && bus.ACK_I;

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end
    end

`ifdef PREWISH_MASK_LFSR_EN
    logic [7:0] lfsr_reg;
    logic       lfsr_fb;

    // Fibonacci form of x^8+x^6+x^5+x^4+1: maximal length, all-zero state unreachable.
    assign lfsr_fb  = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
    assign mask_cur = lfsr_reg;

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            lfsr_reg <= 8'hA5;
        end else if (mask_adv) begin
            lfsr_reg <= {lfsr_reg[6:0], lfsr_fb};
        end
    end
`else
    logic [1:0] idx_reg;

    always_comb begin
        mask_cur = 8'b10101000;
        case (idx_reg)
            2'd0: mask_cur = 8'b10101000;
            2'd1: mask_cur = 8'b11001010;
            2'd2: mask_cur = 8'b11110000;
            2'd3: mask_cur = 8'b10000000;
            default: mask_cur = 8'b10101000;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            idx_reg <= 2'd0;
        end else if (mask_adv) begin
            idx_reg <= idx_reg + 2'd1;
        end
    end
`endif

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_reg  <= IDLE;
            to_cnt_reg <= '0;
            stb_reg    <= 1'b0;
            dat_reg    <= 8'h00;
            busy_reg   <= 1'b0;
            err_reg    <= 1'b0;
            ovr_reg    <= 1'b0;
        end else begin
            // Clear first so that any set below on the same edge takes priority.
            if (bus.CLR_I) begin
                err_reg <= 1'b0;
                ovr_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (tick && bus.EN_I) begin
                        state_reg  <= SEND;
                        stb_reg    <= 1'b1;
                        busy_reg   <= 1'b1;
                        dat_reg    <= mask_cur;
                        to_cnt_reg <= '0;
                    end
                end

                SEND: begin
                    if (tick) begin
                        ovr_reg <= 1'b1;
                    end
                    // ACK is checked before the timeout so a last-cycle ACK still succeeds.
                    if (bus.ACK_I) begin
                        state_reg <= IDLE;
                        stb_reg   <= 1'b0;
                        busy_reg  <= 1'b0;
                    end else if (to_expired) begin
                        state_reg <= IDLE;
                        stb_reg   <= 1'b0;
                        busy_reg  <= 1'b0;
                        err_reg   <= 1'b1;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    stb_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.STB_O  = stb_reg;
    assign bus.DAT_O  = dat_reg;
    assign bus.BUSY_O = busy_reg;
    assign bus.ERR_O  = err_reg;
    assign bus.OVR_O  = ovr_reg;

endmodule

// File: tb/tb_prewish_mask_sender.sv
// Directed bench for prewish_mask_sender with a short tick period (16 clocks).
// Instance a uses a 4-cycle ACK limit, instance b a 32-cycle limit.
module tb_prewish_mask_sender;

    logic clk;
    logic rst_n;
    int   cyc;
    int   last_rise;
    int   n_checks;
    int   n_pass;
    logic [7:0] m_exp;

    prewish_mask_sender_if ifa ();
    prewish_mask_sender_if ifb ();

    prewish_mask_sender #(
        .NEWMASK_CLK_BITS(4),
        .ACK_TIMEOUT_BITS(2)
    ) dut_a (
        .CLK_I(clk),
        .RST_I(rst_n),
        .bus  (ifa)
    );

    prewish_mask_sender #(
        .NEWMASK_CLK_BITS(4),
        .ACK_TIMEOUT_BITS(5)
    ) dut_b (
        .CLK_I(clk),
        .RST_I(rst_n),
        .bus  (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

`ifdef PREWISH_MASK_LFSR_EN
    function automatic logic [7:0] model_first();
        return 8'hA5;
    endfunction
    function automatic logic [7:0] model_next(input logic [7:0] m);
        return {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
    endfunction
`else
    function automatic logic [7:0] model_first();
        return 8'hA8;
    endfunction
    function automatic logic [7:0] model_next(input logic [7:0] m);
        case (m)
            8'hA8:   return 8'hCA;
            8'hCA:   return 8'hF0;
            8'hF0:   return 8'h80;
            default: return 8'hA8;
        endcase
    endfunction
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Waits (bounded) for a strobe on instance a, checks it, optionally acknowledges it.
    task automatic do_send(input string tag, input logic [7:0] exp_dat,
                           input bit chk_period, input bit do_ack);
        int n;
        n = 0;
        while (ifa.STB_O !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_stb"}, 32'(ifa.STB_O), 32'd1);
        if (ifa.STB_O !== 1'b1) return;
        $display("send %s dat=%02h cycle=%0d", tag, ifa.DAT_O, cyc);
        check({tag, "_dat"}, 32'(ifa.DAT_O), 32'(exp_dat));
        check({tag, "_busy"}, 32'(ifa.BUSY_O), 32'd1);
        if (chk_period) check({tag, "_period"}, 32'(cyc - last_rise), 32'd16);
        last_rise = cyc;
        if (do_ack) begin
            ifa.ACK_I = 1'b1;
            @(negedge clk);
            ifa.ACK_I = 1'b0;
            check({tag, "_stb_drop"}, 32'(ifa.STB_O), 32'd0);
            check({tag, "_busy_drop"}, 32'(ifa.BUSY_O), 32'd0);
            @(negedge clk);
            check({tag, "_dat_hold"}, 32'(ifa.DAT_O), 32'(exp_dat));
        end
    endtask

    initial begin
        int n;
        int bad;
        n_checks  = 0;
        n_pass    = 0;
        last_rise = 0;
        m_exp     = model_first();
        rst_n     = 1'b0;
        ifa.EN_I = 1'b0; ifa.CLR_I = 1'b0; ifa.ACK_I = 1'b0;
        ifb.EN_I = 1'b0; ifb.CLR_I = 1'b0; ifb.ACK_I = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_stb",  32'(ifa.STB_O),  32'd0);
        check("rst_dat",  32'(ifa.DAT_O),  32'h00);
        check("rst_busy", 32'(ifa.BUSY_O), 32'd0);
        check("rst_err",  32'(ifa.ERR_O),  32'd0);
        check("rst_ovr",  32'(ifa.OVR_O),  32'd0);

        // Acknowledged sends: one strobe per 16 clocks, table order.
        ifa.EN_I  = 1'b1;
        rst_n     = 1'b1;
        last_rise = cyc;
        for (int i = 0; i < 5; i++) begin
            do_send($sformatf("t1_%0d", i), m_exp, 1'b1, 1'b1);
            m_exp = model_next(m_exp);
        end

        // No ACK: strobe held 4 cycles, timeout with a clear on the same edge.
        do_send("t2_try", m_exp, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("t2_stb_held", 32'(ifa.STB_O), 32'd1);
        ifa.CLR_I = 1'b1;
        @(negedge clk);
        ifa.CLR_I = 1'b0;
        check("t2_stb_timeout", 32'(ifa.STB_O), 32'd0);
        check("t2_err_set_wins", 32'(ifa.ERR_O), 32'd1);
        check("t2_busy_timeout", 32'(ifa.BUSY_O), 32'd0);
        do_send("t2_retry", m_exp, 1'b1, 1'b1);
        m_exp = model_next(m_exp);
        ifa.CLR_I = 1'b1;
        @(negedge clk);
        ifa.CLR_I = 1'b0;
        check("t2_err_clr", 32'(ifa.ERR_O), 32'd0);

        // ACK arriving on the timeout cycle still counts as accepted.
        do_send("t2_late", m_exp, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        ifa.ACK_I = 1'b1;
        @(negedge clk);
        ifa.ACK_I = 1'b0;
        check("t2_late_stb", 32'(ifa.STB_O), 32'd0);
        check("t2_late_err", 32'(ifa.ERR_O), 32'd0);
        m_exp = model_next(m_exp);

        // Disabled for three tick periods, stray ACK while idle.
        ifa.EN_I  = 1'b0;
        ifa.ACK_I = 1'b1;
        bad = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (i == 10) ifa.ACK_I = 1'b0;
            if (ifa.STB_O !== 1'b0 || ifa.ERR_O !== 1'b0 || ifa.OVR_O !== 1'b0) bad++;
        end
        ifa.ACK_I = 1'b0;
        check("t3_quiet", 32'(bad), 32'd0);
        ifa.EN_I = 1'b1;
        do_send("t3_resume", m_exp, 1'b0, 1'b1);
        m_exp = model_next(m_exp);

        // Long ACK delay on instance b: tick during SEND sets OVR, one transfer only.
        ifa.EN_I = 1'b0;
        check("t4_ovr_pre", 32'(ifb.OVR_O), 32'd0);
        ifb.EN_I = 1'b1;
        n = 0;
        while (ifb.STB_O !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t4_stb", 32'(ifb.STB_O), 32'd1);
        $display("send t4_b dat=%02h cycle=%0d", ifb.DAT_O, cyc);
        check("t4_dat", 32'(ifb.DAT_O), 32'(model_first()));
        ifb.EN_I = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifb.STB_O !== 1'b1 || ifb.DAT_O !== model_first()) bad++;
        end
        check("t4_held", 32'(bad), 32'd0);
        check("t4_ovr_set", 32'(ifb.OVR_O), 32'd1);
        ifb.ACK_I = 1'b1;
        @(negedge clk);
        ifb.ACK_I = 1'b0;
        check("t4_stb_drop", 32'(ifb.STB_O), 32'd0);
        check("t4_err", 32'(ifb.ERR_O), 32'd0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ifb.STB_O !== 1'b0) bad++;
        end
        check("t4_single", 32'(bad), 32'd0);
        ifb.CLR_I = 1'b1;
        @(negedge clk);
        ifb.CLR_I = 1'b0;
        check("t4_ovr_clr", 32'(ifb.OVR_O), 32'd0);

        // Reset in the middle of a transfer.
        ifa.EN_I = 1'b1;
        do_send("t5_pre", m_exp, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t5_stb_async", 32'(ifa.STB_O), 32'd0);
        check("t5_busy_async", 32'(ifa.BUSY_O), 32'd0);
        check("t5_dat_async", 32'(ifa.DAT_O), 32'h00);
        repeat (3) @(negedge clk);
        check("t5_stb_in_rst", 32'(ifa.STB_O), 32'd0);
        rst_n     = 1'b1;
        last_rise = cyc;
        m_exp     = model_first();
        do_send("t5_post", m_exp, 1'b1, 1'b1);
        m_exp = model_next(m_exp);

`ifdef PREWISH_MASK_LFSR_EN
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        last_rise = cyc;
        m_exp     = model_first();
        check("t6_seed", 32'(m_exp), 32'hA5);
        for (int i = 0; i < 255; i++) begin
            do_send($sformatf("t6_%0d", i), m_exp, 1'b1, 1'b1);
            check("t6_nonzero", 32'(ifa.DAT_O != 8'h00), 32'd1);
            m_exp = model_next(m_exp);
        end
        do_send("t6_wrap", 8'hA5, 1'b1, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
